icb_cmd_loader: RTL and testbench

ICB_CMD_LOADER -- requirements
Module: icb_cmd_loader

---
 rtl/icb_pkg.sv | 25 ++
 rtl/icb_cmd_slot.sv | 52 +++++
 rtl/icb_cmd_loader.sv | 204 ++++++++++++++++++++
 tb/tb_icb_cmd_loader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icb_pkg.sv
// Shared ICB definitions for the command loader: bus widths, default
// register addresses and the loader state encoding.
package icb_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;
    localparam int ICB_MW = 4;
    localparam int OUT_W  = 4;
    localparam int IDX_W  = 13;

    localparam logic [ICB_AW-1:0] CTRL_ADDR_DEF   = 32'h1004_2000;
    localparam logic [ICB_AW-1:0] STATUS_ADDR_DEF = 32'h1004_2010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_GO_SET,
        ST_GO_CLR,
        ST_DRAIN,
        ST_POLL,
        ST_POLL_WAIT,
        ST_FIN
    } state_e;

endpackage

// File: rtl/icb_cmd_slot.sv
// Single registered ICB command; holds valid/addr/wdata/read until accepted.
// Ports: clk_i/rst_i, load_i + addr/wdata/read_i in, ready_i from bus,
// valid/addr/wdata/read_o to bus, free_o (may load now), accept_o.
module icb_cmd_slot
    import icb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ICB_AW-1:0] addr_i,
    input  logic [ICB_DW-1:0] wdata_i,
    input  logic              read_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ICB_AW-1:0] addr_o,
    output logic [ICB_DW-1:0] wdata_o,
    output logic              read_o,
    output logic              free_o,
    output logic              accept_o
);

    logic              valid_q;
    logic [ICB_AW-1:0] addr_q;
    logic [ICB_DW-1:0] wdata_q;
    logic              read_q;

    assign accept_o = valid_q && ready_i;
    // Refill in the same cycle the current command is taken.
    assign free_o   = !valid_q || ready_i;

    assign valid_o  = valid_q;
    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;
    assign read_o   = read_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            read_q  <= read_i;
        end else if (accept_o) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/icb_cmd_loader.sv
// ICB initiator: streams source words as writes, pulses the go register,
// drains responses and polls status bit0 until done.
// Ports: clk/rst, start/base_addr/word_cnt, src_* stream, icb_cmd_*/icb_rsp_*
// bus, busy/done/err status.
module icb_cmd_loader
    import icb_pkg::*;
#(
    parameter int unsigned       ADDR_STEP       = 1,
    parameter logic [ICB_AW-1:0] CTRL_ADDR       = CTRL_ADDR_DEF,
    parameter logic [ICB_AW-1:0] STATUS_ADDR     = STATUS_ADDR_DEF,
    parameter int unsigned       MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ICB_AW-1:0] base_addr,
    input  logic [IDX_W-1:0]  word_cnt,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [ICB_DW-1:0] src_data,
    output logic              icb_cmd_valid,
    input  logic              icb_cmd_ready,
    output logic              icb_cmd_read,
    output logic [ICB_AW-1:0] icb_cmd_addr,
    output logic [ICB_DW-1:0] icb_cmd_wdata,
    output logic [ICB_MW-1:0] icb_cmd_wmask,
    input  logic              icb_rsp_valid,
    output logic              icb_rsp_ready,
    input  logic [ICB_DW-1:0] icb_rsp_rdata,
    input  logic              icb_rsp_err,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [OUT_W-1:0]  MAX_O = OUT_W'(MAX_OUTSTANDING);
    localparam logic [ICB_AW-1:0] STEP  = ICB_AW'(ADDR_STEP);

    state_e             state_q;
    logic [ICB_AW-1:0]  base_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [OUT_W-1:0]   out_q;
    logic [OUT_W-1:0]   out_d;
    logic               err_q;
    logic               busy_q;
    logic               done_q;

    logic               slot_valid;
    logic               slot_free;
    logic               accept;
    logic               can_load;
    logic               words_left;
    logic               rsp_ok;
    logic [OUT_W:0]     in_use;

    logic               ld;
    logic [ICB_AW-1:0]  ld_addr;
    logic [ICB_DW-1:0]  ld_wdata;
    logic               ld_read;

    logic               unused_rdata;

    assign unused_rdata  = ^icb_rsp_rdata[ICB_DW-1:1];

    assign icb_cmd_wmask = {ICB_MW{1'b1}};
    assign icb_rsp_ready = 1'b1;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign icb_cmd_valid = slot_valid;

    // A command parked in the slot counts against the limit, so a held
    // command can never push outstanding past MAX_OUTSTANDING.
    assign in_use     = {1'b0, out_q} + {{OUT_W{1'b0}}, slot_valid};
    assign can_load   = slot_free && (in_use < {1'b0, MAX_O});
    assign words_left = (idx_q != cnt_q);
    assign rsp_ok     = icb_rsp_valid && (out_q != '0);

    assign src_ready = (state_q == ST_DATA) && words_left &&
                       src_valid && can_load;

    always_comb begin
        ld       = 1'b0;
        ld_addr  = '0;
        ld_wdata = '0;
        ld_read  = 1'b0;
        unique case (state_q)
            ST_DATA: begin
                ld       = src_ready;
                ld_addr  = base_q + ICB_AW'(idx_q) * STEP;
                ld_wdata = src_data;
            end
            ST_GO_SET: begin
                ld       = can_load;
                ld_addr  = CTRL_ADDR;
                ld_wdata = 32'h1;
            end
            ST_GO_CLR: begin
                ld       = can_load;
                ld_addr  = CTRL_ADDR;
            end
            ST_POLL: begin
                ld       = can_load;
                ld_addr  = STATUS_ADDR;
                ld_read  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        out_d = out_q;
        if (accept && !rsp_ok) begin
            out_d = out_q + 1'b1;
        end else if (!accept && rsp_ok) begin
            out_d = out_q - 1'b1;
        end
    end

    icb_cmd_slot u_slot (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (ld),
        .addr_i   (ld_addr),
        .wdata_i  (ld_wdata),
        .read_i   (ld_read),
        .ready_i  (icb_cmd_ready),
        .valid_o  (slot_valid),
        .addr_o   (icb_cmd_addr),
        .wdata_o  (icb_cmd_wdata),
        .read_o   (icb_cmd_read),
        .free_o   (slot_free),
        .accept_o (accept)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            done_q <= 1'b0;
            // Stray responses (nothing outstanding) are flagged too.
            if (icb_rsp_valid && (icb_rsp_err || out_q == '0)) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        cnt_q   <= word_cnt;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (word_cnt == '0) ? ST_GO_SET : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (src_ready) begin
                        idx_q <= idx_q + 1'b1;
                    end
                    // Leave only once the last word's command is taken.
                    if (!words_left && slot_free) begin
                        state_q <= ST_GO_SET;
                    end
                end
                ST_GO_SET: begin
                    if (can_load) state_q <= ST_GO_CLR;
                end
                ST_GO_CLR: begin
                    if (can_load) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!slot_valid && out_q == '0) state_q <= ST_POLL;
                end
                ST_POLL: begin
                    if (can_load) state_q <= ST_POLL_WAIT;
                end
                ST_POLL_WAIT: begin
                    if (rsp_ok) begin
                        if (icb_rsp_rdata[0]) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_POLL;
                        end
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icb_cmd_loader.sv
// Directed bench for icb_cmd_loader: scoreboarded command stream,
// delayed-response bus model, stall/limit/poll/reset scenarios.
module tb_icb_cmd_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [12:0] word_cnt;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src_data = 32'h0;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready = 1'b1;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid = 1'b0;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata = 32'h0;
    logic        icb_rsp_err = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    icb_cmd_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .word_cnt      (word_cnt),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_data      (src_data),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
    } cmd_t;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] rdata;
        logic        e;
    } rsp_t;

    cmd_t        exp_q[$];
    rsp_t        pend_q[$];
    logic [31:0] stat_q[$];

    int nerr = 0;
    int nchk = 0;
    int cyc = 0;
    int lat = 2;
    int sidx = 0;
    int done_cnt = 0;
    int srdy_cnt = 0;
    int srdy_stall = 0;
    int hold_chk = 0;
    int acc_pre = 0;
    int tb_out = 0;
    int max_out = 0;
    int stall_left = 0;
    logic [31:0] stall_addr = 32'h0;
    logic [31:0] data_base = 32'hA000_0000;
    bit   rsp_seen = 0;
    bit   err_inject = 0;
    bit   consumed = 0;
    bit   lat_pend = 0;
    logic [31:0] lat_data = 32'h0;
    bit   hold_pend = 0;
    cmd_t hold_cmd;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus/source model: responses after `lat` cycles, optional ready stall.
    always @(posedge clk) begin
        rsp_t r;
        cyc++;
        #1;
        if (rst) begin
            icb_rsp_valid = 1'b0;
            icb_rsp_rdata = 32'h0;
            icb_rsp_err   = 1'b0;
            icb_cmd_ready = 1'b1;
        end else begin
            if (pend_q.size() > 0 && pend_q[0].due <= 32'(cyc)) begin
                r = pend_q.pop_front();
                icb_rsp_valid = 1'b1;
                icb_rsp_rdata = r.rdata;
                icb_rsp_err   = r.e;
            end else begin
                icb_rsp_valid = 1'b0;
                icb_rsp_rdata = 32'h0;
                icb_rsp_err   = 1'b0;
            end
            if (stall_left > 0 && icb_cmd_valid &&
                icb_cmd_addr == stall_addr) begin
                icb_cmd_ready = 1'b0;
                stall_left--;
            end else begin
                icb_cmd_ready = 1'b1;
            end
        end
        if (consumed) sidx++;
        src_data = data_base + 32'(sidx);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        cmd_t e;
        logic [31:0] rd;
        if (!rst) begin
            if (done) done_cnt++;
            if (src_ready) srdy_cnt++;
            if (src_ready && icb_cmd_valid && !icb_cmd_ready) srdy_stall++;
            if (lat_pend) begin
                check("src2cmd_valid", 32'(icb_cmd_valid), 32'd1);
                check("src2cmd_wdata", icb_cmd_wdata, lat_data);
            end
            lat_pend = src_ready && src_valid;
            lat_data = src_data;
            consumed = src_ready && src_valid;
            if (hold_pend) begin
                hold_chk++;
                check("hold_valid", 32'(icb_cmd_valid), 32'd1);
                check("hold_addr", icb_cmd_addr, hold_cmd.addr);
                check("hold_wdata", icb_cmd_wdata, hold_cmd.wdata);
                check("hold_read", 32'(icb_cmd_read), 32'(hold_cmd.rd));
            end
            hold_pend = icb_cmd_valid && !icb_cmd_ready;
            hold_cmd  = '{icb_cmd_addr, icb_cmd_wdata, icb_cmd_read};
            if (icb_cmd_valid && icb_cmd_ready) begin
                if (!rsp_seen) acc_pre++;
                tb_out++;
                rd = 32'h0;
                if (exp_q.size() == 0) begin
                    check("cmd_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_addr", icb_cmd_addr, e.addr);
                    check("cmd_read", 32'(icb_cmd_read), 32'(e.rd));
                    check("cmd_wmask", 32'(icb_cmd_wmask), 32'hF);
                    if (!e.rd) check("cmd_wdata", icb_cmd_wdata, e.wdata);
                    else rd = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h1;
                end
                pend_q.push_back('{32'(cyc + lat), rd, err_inject});
                err_inject = 0;
            end
            if (icb_rsp_valid) begin
                tb_out--;
                rsp_seen = 1;
            end
            if (tb_out > max_out) max_out = tb_out;
        end
    end

    task automatic run(input string nm, input logic [31:0] base,
                       input logic [12:0] cnt, input int nzero,
                       input bit poke);
        int d0;
        int to;
        for (int i = 0; i < int'(cnt); i++)
            exp_q.push_back('{base + 32'(i), data_base + 32'(sidx + i), 1'b0});
        exp_q.push_back('{32'h1004_2000, 32'h1, 1'b0});
        exp_q.push_back('{32'h1004_2000, 32'h0, 1'b0});
        for (int i = 0; i <= nzero; i++) begin
            exp_q.push_back('{32'h1004_2010, 32'h0, 1'b1});
            stat_q.push_back((i == nzero) ? 32'h1 : 32'h0);
        end
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        word_cnt = cnt;
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy_after_start"}, 32'(busy), 32'd1);
        check({nm, "_err_clr_on_start"}, 32'(err), 32'd0);
        if (poke) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            base_addr = 32'h5555_0000;
            word_cnt = 13'd7;
            @(negedge clk);
            start = 1'b0;
        end
        to = 0;
        while (done_cnt == d0 && to < 3000) begin
            @(negedge clk);
            #1;
            to++;
        end
        check({nm, "_done_in_time"}, 32'(to < 3000), 32'd1);
        repeat (2) @(negedge clk);
        check({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({nm, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
        check({nm, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int to;
        rst = 1'b1;
        start = 1'b0;
        base_addr = 32'h0;
        word_cnt = 13'd0;
        src_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(icb_cmd_valid), 32'd0);
        check("rst_read", 32'(icb_cmd_read), 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", icb_cmd_addr, 32'h0);
        check("rst_wdata", icb_cmd_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        src_valid = 1'b1;

        run("basic", 32'h1004_2009, 13'd3, 0, 1'b1);
        check("basic_err", 32'(err), 32'd0);

        to = srdy_cnt;
        run("zero", 32'h1004_3000, 13'd0, 0, 1'b0);
        check("zero_no_src_ready", 32'(srdy_cnt - to), 32'd0);

        stall_addr = 32'h2000_0001;
        stall_left = 5;
        to = hold_chk;
        srdy_stall = 0;
        run("stall", 32'h2000_0000, 13'd3, 0, 1'b0);
        check("stall_cycles", 32'(hold_chk - to), 32'd5);
        check("stall_src_ready", 32'(srdy_stall), 32'd0);

        lat = 10;
        rsp_seen = 0;
        acc_pre = 0;
        max_out = 0;
        run("limit", 32'h3000_0000, 13'd8, 0, 1'b0);
        check("limit_acc_before_rsp", 32'(acc_pre), 32'd4);
        check("limit_max_out", 32'(max_out), 32'd4);

        lat = 2;
        err_inject = 1;
        run("poll", 32'h4000_0000, 13'd2, 2, 1'b0);
        check("poll_err_sticky", 32'(err), 32'd1);
        run("clr", 32'h4000_0100, 13'd0, 0, 1'b0);
        check("clr_err", 32'(err), 32'd0);

        run("wrap", 32'hFFFF_FFFF, 13'd2, 0, 1'b0);

        lat = 20;
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{32'h5000_0000 + 32'(i),
                              data_base + 32'(sidx + i), 1'b0});
        @(negedge clk);
        start = 1'b1;
        base_addr = 32'h5000_0000;
        word_cnt = 13'd8;
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while (tb_out < 2 && to < 200) begin
            @(negedge clk);
            #1;
            to++;
        end
        check("abort_two_out", 32'(tb_out), 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(icb_cmd_valid), 32'd0);
        check("arst_read", 32'(icb_cmd_read), 32'd0);
        check("arst_src_ready", 32'(src_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_addr", icb_cmd_addr, 32'h0);
        check("arst_wdata", icb_cmd_wdata, 32'h0);
        exp_q.delete();
        pend_q.delete();
        stat_q.delete();
        tb_out = 0;
        lat_pend = 0;
        hold_pend = 0;
        consumed = 0;
        err_inject = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat = 2;
        @(negedge clk);
        check("post_rst_valid", 32'(icb_cmd_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        run("after_rst", 32'h1004_2009, 13'd3, 0, 1'b0);
        check("after_rst_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
